// File: rtl/rr_serial_arbiter.sv
// rtl/rr_serial_arbiter.sv - round-robin serial bus arbiter with address-decoded slave forwarding
// Grants one master at a time, receives its serial address, replays it to the decoded slave, then forwards data.
module rr_serial_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 3,
  parameter int ADDR_WIDTH  = 12,
  parameter int SEL_BITS    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] m_req,
  input  logic [NUM_MASTERS-1:0] m_valid,
  input  logic [NUM_MASTERS-1:0] m_address_valid,
  input  logic [NUM_MASTERS-1:0] m_address,
  input  logic [NUM_MASTERS-1:0] m_data,
  output logic [NUM_MASTERS-1:0] m_grant,
  output logic [NUM_MASTERS-1:0] m_ready,
  output logic [NUM_MASTERS-1:0] m_error,
  input  logic [NUM_SLAVES-1:0]  s_ready,
  output logic [NUM_SLAVES-1:0]  s_address,
  output logic [NUM_SLAVES-1:0]  s_data,
  output logic [NUM_SLAVES-1:0]  s_valid
);

  localparam int MIDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W  = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    ADDR_RX,
    WAIT_SLAVE,
    ADDR_TX,
    DATA,
    ERR
  } state_t;

  state_t                state;
  logic [MIDX_W-1:0]     last;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_W-1:0]      cnt;
  logic [SEL_BITS-1:0]   sel_q;

  logic                  m_valid_g;
  logic                  m_addr_v_g;
  logic                  m_req_g;
  logic                  m_addr_g;
  logic                  m_data_g;
  logic                  s_ready_sel;
  logic [NUM_SLAVES-1:0] sel_oh;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [SEL_BITS-1:0]   sel_new;
  logic [MIDX_W-1:0]     winner;
  logic                  rr_found;
  int                    rr_idx;

  // The registered one-hot grant doubles as the mux select for the owning master.
  assign m_valid_g  = |(m_valid & m_grant);
  assign m_addr_v_g = |(m_address_valid & m_grant);
  assign m_req_g    = |(m_req & m_grant);
  assign m_addr_g   = |(m_address & m_grant);
  assign m_data_g   = |(m_data & m_grant);

  assign addr_next = {addr_q[ADDR_WIDTH-2:0], m_addr_g};
  assign sel_new   = addr_next[ADDR_WIDTH-1 -: SEL_BITS];

  // An out-of-range sel decodes to an all-zero mask, so no slave port can toggle.
  always_comb begin
    sel_oh = '0;
    for (int j = 0; j < NUM_SLAVES; j++) begin
      sel_oh[j] = (sel_q == SEL_BITS'(j));
    end
  end

  assign s_ready_sel = |(s_ready & sel_oh);

  always_comb begin
    winner   = last;
    rr_found = 1'b0;
    rr_idx   = 0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      rr_idx = int'(last) + i;
      if (rr_idx >= NUM_MASTERS) rr_idx = rr_idx - NUM_MASTERS;
      if (!rr_found && m_req[rr_idx]) begin
        winner   = MIDX_W'(rr_idx);
        rr_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last      <= MIDX_W'(NUM_MASTERS - 1);
      addr_q    <= '0;
      cnt       <= '0;
      sel_q     <= '0;
      m_grant   <= '0;
      m_ready   <= '0;
      m_error   <= '0;
      s_valid   <= '0;
      s_address <= '0;
      s_data    <= '0;
    end else begin
      m_error <= '0;
      case (state)
        IDLE: begin
          if (rr_found) begin
            m_grant <= NUM_MASTERS'(1) << winner;
            last    <= winner;
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (!m_req_g) begin
            m_grant <= '0;
            state   <= IDLE;
          end else if (m_valid_g && m_addr_v_g) begin
            cnt   <= '0;
            state <= ADDR_RX;
          end
        end
        default: begin
          // Dropping valid anywhere past GRANT ends the transaction on this edge.
          if (!m_valid_g) begin
            m_grant   <= '0;
            m_ready   <= '0;
            s_valid   <= '0;
            s_address <= '0;
            s_data    <= '0;
            state     <= IDLE;
          end else begin
            case (state)
              ADDR_RX: begin
                addr_q <= addr_next;
                cnt    <= cnt + 1'b1;
                if (cnt == CNT_W'(ADDR_WIDTH - 1)) begin
                  sel_q <= sel_new;
                  if (int'(sel_new) >= NUM_SLAVES) begin
                    m_error <= m_grant;
                    state   <= ERR;
                  end else begin
                    state <= WAIT_SLAVE;
                  end
                end
              end
              WAIT_SLAVE: begin
                if (s_ready_sel) begin
                  s_valid   <= sel_oh;
                  s_address <= sel_oh & {NUM_SLAVES{addr_q[ADDR_WIDTH-1]}};
                  addr_q    <= addr_q << 1;
                  cnt       <= '0;
                  state     <= ADDR_TX;
                end
              end
              ADDR_TX: begin
                if (cnt == CNT_W'(ADDR_WIDTH - 1)) begin
                  s_address <= '0;
                  m_ready   <= m_grant & {NUM_MASTERS{s_ready_sel}};
                  state     <= DATA;
                end else begin
                  s_address <= sel_oh & {NUM_SLAVES{addr_q[ADDR_WIDTH-1]}};
                  addr_q    <= addr_q << 1;
                  cnt       <= cnt + 1'b1;
                end
              end
              DATA: begin
                s_data  <= sel_oh & {NUM_SLAVES{m_data_g}};
                m_ready <= m_grant & {NUM_MASTERS{s_ready_sel}};
              end
              default: begin
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule
